// File: rtl/red_pitaya_hk_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hk_pkg
// Purpose  : Shared definitions for the housekeeping / GPIO block: register
//            offsets (low 20 address bits), edge-mode bit indices, DNA
//            sequencing constants and the DNA reader state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hk_pkg;

  // Register offsets, compared against sys_addr[19:0]
  localparam logic [19:0] c_addr_id         = 20'h00;
  localparam logic [19:0] c_addr_dna_lo     = 20'h04;
  localparam logic [19:0] c_addr_dna_hi     = 20'h08;
  localparam logic [19:0] c_addr_ctrl       = 20'h0C;
  localparam logic [19:0] c_addr_dir_p      = 20'h10;
  localparam logic [19:0] c_addr_dir_n      = 20'h14;
  localparam logic [19:0] c_addr_dat_p      = 20'h18;
  localparam logic [19:0] c_addr_dat_n      = 20'h1C;
  localparam logic [19:0] c_addr_in_p       = 20'h20;
  localparam logic [19:0] c_addr_in_n       = 20'h24;
  localparam logic [19:0] c_addr_set_p      = 20'h28;
  localparam logic [19:0] c_addr_set_n      = 20'h2C;
  localparam logic [19:0] c_addr_led        = 20'h30;
  localparam logic [19:0] c_addr_blink_mask = 20'h34;
  localparam logic [19:0] c_addr_blink_per  = 20'h38;
  localparam logic [19:0] c_addr_en_p       = 20'h40;
  localparam logic [19:0] c_addr_en_n       = 20'h44;
  localparam logic [19:0] c_addr_stat_p     = 20'h48;
  localparam logic [19:0] c_addr_stat_n     = 20'h4C;
  localparam logic [19:0] c_addr_mode       = 20'h50;

  // Bit positions inside the edge-mode register
  localparam int unsigned c_mode_rise = 0;
  localparam int unsigned c_mode_fall = 1;

  // DNA sequencing
  localparam int unsigned c_dna_bits      = 57;
  localparam int unsigned c_dna_load_clks = 2;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } dna_state_t;

endpackage
`default_nettype wire

// File: rtl/red_pitaya_hk_gpio_if.sv
`default_nettype none
// ============================================================================
// Interface : red_pitaya_hk_gpio_if
// Purpose   : System-bus slot of the housekeeping block. The master drives
//             address, write data, byte select and the read/write strobes;
//             the slave returns read data, error and acknowledge.
// Signals   : addr[31:0], wdata[31:0], sel[3:0], wen, ren  (master -> slave)
//             rdata[31:0], err, ack                         (slave -> master)
// Revision  : 1.0 - initial release
// ============================================================================
interface red_pitaya_hk_gpio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        err;
  logic        ack;

  modport master (
    output addr, wdata, sel, wen, ren,
    input  rdata, err, ack
  );

  modport slave (
    input  addr, wdata, sel, wen, ren,
    output rdata, err, ack
  );
endinterface
`default_nettype wire

// File: rtl/red_pitaya_hk_gpio_dna_reader.sv
`default_nettype none
// ============================================================================
// Module   : hk_dna_reader
// Purpose  : Reads the 57-bit device DNA once after reset. A divided DNA
//            clock (half period 2^DNA_DIV clk cycles) paces the sequence:
//            READ for 2 DNA clocks, then 57 shifts sampling DOUT MSB first.
//            The DNA port is modelled as a shift register in the clk domain,
//            advanced on the cycles where the divided clock would rise, so
//            no derived clock (and no BUFH) enters the fabric.
// Ports    : clk_i, rstn_i      - clock, async active-low reset
//            dna_value[56:0]    - captured DNA, 0 until the sequence ends
//            dna_done           - high once the value is frozen
// Revision : 1.0 - initial release
// ============================================================================
module hk_dna_reader
  import hk_pkg::*;
#(
  parameter int unsigned DNA_DIV = 3,
  parameter logic [56:0] DNA     = 57'h0823456789ABCDE
) (
  input  wire logic        clk_i,
  input  wire logic        rstn_i,
  output logic [56:0]      dna_value,
  output logic             dna_done
);

  localparam int unsigned            c_div_w    = DNA_DIV + 1;
  // Divider value on which the DNA clock would go from low to high
  localparam logic [c_div_w-1:0]     c_rise_cnt = c_div_w'((1 << DNA_DIV) - 1);

  dna_state_t         r_state;
  dna_state_t         w_state_nxt;
  logic [c_div_w-1:0] r_div;
  logic               w_dna_rise;
  logic [5:0]         r_bit_cnt;
  logic               w_port_read;
  logic               w_port_shift;
  logic [56:0]        r_port_sr;
  logic [56:0]        r_value;

  assign w_dna_rise = (r_div == c_rise_cnt);

  // Clock divider stops once the value is captured
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_div <= '0;
    end else if (r_state != ST_DONE) begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_port_read  = 1'b0;
    w_port_shift = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_port_read = 1'b1;
        if (w_dna_rise && (r_bit_cnt == 6'(c_dna_load_clks - 1))) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_port_shift = 1'b1;
        if (w_dna_rise && (r_bit_cnt == 6'(c_dna_bits - 1))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // Per-phase DNA clock counter, port model and capture register.
  // DOUT is the port MSB before the shift, so sampling and shifting on the
  // same rising DNA clock collects the value MSB first.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bit_cnt <= '0;
      r_port_sr <= '0;
      r_value   <= '0;
    end else begin
      if (w_state_nxt != r_state) begin
        r_bit_cnt <= '0;
      end else if (w_dna_rise && (w_port_read || w_port_shift)) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_dna_rise) begin
        if (w_port_read) begin
          r_port_sr <= DNA;
        end else if (w_port_shift) begin
          r_port_sr <= {r_port_sr[55:0], 1'b0};
          r_value   <= {r_value[55:0], r_port_sr[56]};
        end
      end
    end
  end

  assign dna_value = r_value;
  assign dna_done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: rtl/red_pitaya_hk_gpio.sv
`default_nettype none
// ============================================================================
// Module   : red_pitaya_hk_gpio
// Purpose  : Housekeeping block: ID and DNA readout, expansion-connector GPIO
//            with synchronised inputs and per-bit edge interrupts, LEDs with
//            hardware blink, global digital loopback enable.
// Ports    : clk_i, rstn_i                 - clock, async active-low reset
//            led_o[DWL-1:0]                - LED drive (register ^ blink)
//            digital_loop                  - loopback enable
//            exp_{p,n}_dat_i[DWE-1:0]      - asynchronous pad inputs
//            exp_{p,n}_dat_o / _dir_o      - pad output data / output enable
//            irq_o                         - registered level interrupt
//            sys                           - system-bus slave port
// Revision : 1.0 - initial release
// ============================================================================
module red_pitaya_hk_gpio
  import hk_pkg::*;
#(
  parameter int unsigned DWL     = 8,
  parameter int unsigned DWE     = 8,
  parameter int unsigned SYNC    = 2,
  parameter int unsigned DNA_DIV = 3,
  parameter logic [31:0] ID      = 32'h2,
  parameter logic [56:0] DNA     = 57'h0823456789ABCDE
) (
  input  wire logic           clk_i,
  input  wire logic           rstn_i,
  output logic [DWL-1:0]      led_o,
  output logic                digital_loop,
  input  wire logic [DWE-1:0] exp_p_dat_i,
  input  wire logic [DWE-1:0] exp_n_dat_i,
  output logic [DWE-1:0]      exp_p_dat_o,
  output logic [DWE-1:0]      exp_n_dat_o,
  output logic [DWE-1:0]      exp_p_dir_o,
  output logic [DWE-1:0]      exp_n_dir_o,
  output logic                irq_o,
  red_pitaya_hk_gpio_if.slave sys
);

  logic [19:0]         w_addr;
  logic                w_req;
  logic [31:0]         w_rdata;
  logic [31:0]         r_rdata;
  logic                r_ack;

  logic                r_digital_loop;
  logic [DWE-1:0]      r_dir_p, r_dir_n;
  logic [DWE-1:0]      r_dat_p, r_dat_n;
  logic [DWL-1:0]      r_led, r_mask;
  logic [31:0]         r_period;
  logic [DWE-1:0]      r_en_p, r_en_n;
  logic [DWE-1:0]      r_stat_p, r_stat_n;
  logic [1:0]          r_mode;
  logic                r_irq;

  logic [SYNC*DWE-1:0] r_sync_p, r_sync_n;
  logic [DWE-1:0]      w_sync_p, w_sync_n;
  logic [DWE-1:0]      r_prev_p, r_prev_n;
  logic [DWE-1:0]      w_edge_p, w_edge_n;
  logic [DWE-1:0]      w_clr_p, w_clr_n;

  logic [31:0]         r_blk_cnt;
  logic                r_phase;
  logic                w_per_wr;

  logic [56:0]         w_dna_value;
  logic                w_dna_done;
  logic                w_unused;

  assign w_addr   = sys.addr[19:0];
  assign w_req    = sys.wen | sys.ren;
  // Byte selects are ignored: only full-word accesses are supported
  assign w_unused = ^{sys.sel, sys.addr[31:20]};

  hk_dna_reader #(
    .DNA_DIV (DNA_DIV),
    .DNA     (DNA)
  ) u_dna (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .dna_value (w_dna_value),
    .dna_done  (w_dna_done)
  );

  // --------------------------------------------------------------------------
  // Bus response: read data reflects registers before any same-cycle write
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      c_addr_id:         w_rdata = ID;
      c_addr_dna_lo:     w_rdata = w_dna_value[31:0];
      c_addr_dna_hi:     w_rdata = 32'(w_dna_value[56:32]);
      c_addr_ctrl:       w_rdata = {30'd0, w_dna_done, r_digital_loop};
      c_addr_dir_p:      w_rdata = 32'(r_dir_p);
      c_addr_dir_n:      w_rdata = 32'(r_dir_n);
      c_addr_dat_p:      w_rdata = 32'(r_dat_p);
      c_addr_dat_n:      w_rdata = 32'(r_dat_n);
      c_addr_in_p:       w_rdata = 32'(w_sync_p);
      c_addr_in_n:       w_rdata = 32'(w_sync_n);
      c_addr_led:        w_rdata = 32'(r_led);
      c_addr_blink_mask: w_rdata = 32'(r_mask);
      c_addr_blink_per:  w_rdata = r_period;
      c_addr_en_p:       w_rdata = 32'(r_en_p);
      c_addr_en_n:       w_rdata = 32'(r_en_n);
      c_addr_stat_p:     w_rdata = 32'(r_stat_p);
      c_addr_stat_n:     w_rdata = 32'(r_stat_n);
      c_addr_mode:       w_rdata = {30'd0, r_mode};
      default:           w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_req ? w_rdata : '0;
    end
  end

  assign sys.ack   = r_ack;
  assign sys.rdata = r_rdata;
  assign sys.err   = 1'b0;

  // --------------------------------------------------------------------------
  // Plain read/write registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_digital_loop <= 1'b0;
      r_dir_p        <= '0;
      r_dir_n        <= '0;
      r_dat_p        <= '0;
      r_dat_n        <= '0;
      r_led          <= '0;
      r_mask         <= '0;
      r_period       <= '0;
      r_en_p         <= '0;
      r_en_n         <= '0;
      r_mode         <= '0;
    end else if (sys.wen) begin
      case (w_addr)
        c_addr_ctrl:       r_digital_loop <= sys.wdata[0];
        c_addr_dir_p:      r_dir_p        <= sys.wdata[DWE-1:0];
        c_addr_dir_n:      r_dir_n        <= sys.wdata[DWE-1:0];
        c_addr_dat_p:      r_dat_p        <= sys.wdata[DWE-1:0];
        c_addr_dat_n:      r_dat_n        <= sys.wdata[DWE-1:0];
        c_addr_set_p:      r_dat_p        <= r_dat_p | sys.wdata[DWE-1:0];
        c_addr_set_n:      r_dat_n        <= r_dat_n | sys.wdata[DWE-1:0];
        c_addr_led:        r_led          <= sys.wdata[DWL-1:0];
        c_addr_blink_mask: r_mask         <= sys.wdata[DWL-1:0];
        c_addr_blink_per:  r_period       <= sys.wdata;
        c_addr_en_p:       r_en_p         <= sys.wdata[DWE-1:0];
        c_addr_en_n:       r_en_n         <= sys.wdata[DWE-1:0];
        c_addr_mode:       r_mode         <= sys.wdata[1:0];
        default: ;
      endcase
    end
  end

  assign digital_loop = r_digital_loop;
  assign exp_p_dir_o  = r_dir_p;
  assign exp_n_dir_o  = r_dir_n;
  assign exp_p_dat_o  = r_dat_p;
  assign exp_n_dat_o  = r_dat_n;

  // --------------------------------------------------------------------------
  // Input synchronisers (stage 0 in the low DWE bits) and edge detection
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync_p <= '0;
      r_sync_n <= '0;
      r_prev_p <= '0;
      r_prev_n <= '0;
    end else begin
      r_sync_p <= {r_sync_p[(SYNC-1)*DWE-1:0], exp_p_dat_i};
      r_sync_n <= {r_sync_n[(SYNC-1)*DWE-1:0], exp_n_dat_i};
      r_prev_p <= w_sync_p;
      r_prev_n <= w_sync_n;
    end
  end

  assign w_sync_p = r_sync_p[SYNC*DWE-1 -: DWE];
  assign w_sync_n = r_sync_n[SYNC*DWE-1 -: DWE];

  assign w_edge_p = ( w_sync_p & ~r_prev_p & {DWE{r_mode[c_mode_rise]}})
                  | (~w_sync_p &  r_prev_p & {DWE{r_mode[c_mode_fall]}});
  assign w_edge_n = ( w_sync_n & ~r_prev_n & {DWE{r_mode[c_mode_rise]}})
                  | (~w_sync_n &  r_prev_n & {DWE{r_mode[c_mode_fall]}});

  // --------------------------------------------------------------------------
  // Interrupt status: a new edge is OR-ed in after the clear, so it survives
  // a coincident write-1-clear
  // --------------------------------------------------------------------------
  assign w_clr_p = (sys.wen && (w_addr == c_addr_stat_p)) ? sys.wdata[DWE-1:0] : '0;
  assign w_clr_n = (sys.wen && (w_addr == c_addr_stat_n)) ? sys.wdata[DWE-1:0] : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stat_p <= '0;
      r_stat_n <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_stat_p <= (r_stat_p & ~w_clr_p) | w_edge_p;
      r_stat_n <= (r_stat_n & ~w_clr_n) | w_edge_n;
      r_irq    <= (|(r_stat_p & r_en_p)) | (|(r_stat_n & r_en_n));
    end
  end

  assign irq_o = r_irq;

  // --------------------------------------------------------------------------
  // LED blink: counter runs 0..period, so each phase lasts period+1 cycles
  // --------------------------------------------------------------------------
  assign w_per_wr = sys.wen && (w_addr == c_addr_blink_per);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_per_wr || (r_period == 32'd0)) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (r_blk_cnt == r_period) begin
      r_blk_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_blk_cnt <= r_blk_cnt + 32'd1;
    end
  end

  assign led_o = r_led ^ (r_mask & {DWL{r_phase}});

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_hk_gpio.sv
`default_nettype none
// ============================================================================
// Module   : tb_red_pitaya_hk_gpio
// Purpose  : Self-checking bench for red_pitaya_hk_gpio: register map, GPIO
//            set, randomised edge interrupts against a reference model,
//            write-1-clear collision, LED blink timing and DNA readout
//            including a reset in the middle of the sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_hk_gpio;

  localparam int unsigned DWL     = 8;
  localparam int unsigned DWE     = 8;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned DNA_DIV = 3;
  localparam logic [31:0] c_id    = 32'h2;
  localparam logic [56:0] c_dna   = 57'h0823456789ABCDE;

  localparam logic [31:0] A_ID = 32'h00, A_DNA_LO = 32'h04, A_DNA_HI = 32'h08;
  localparam logic [31:0] A_CTRL = 32'h0C, A_DIR_P = 32'h10, A_DIR_N = 32'h14;
  localparam logic [31:0] A_DAT_P = 32'h18, A_DAT_N = 32'h1C;
  localparam logic [31:0] A_IN_P = 32'h20, A_IN_N = 32'h24;
  localparam logic [31:0] A_SET_P = 32'h28, A_SET_N = 32'h2C;
  localparam logic [31:0] A_LED = 32'h30, A_MASK = 32'h34, A_PER = 32'h38;
  localparam logic [31:0] A_EN_P = 32'h40, A_EN_N = 32'h44;
  localparam logic [31:0] A_ST_P = 32'h48, A_ST_N = 32'h4C, A_MODE = 32'h50;

  logic clk = 1'b0;
  logic rstn_i = 1'b0;
  logic [DWL-1:0] led_o;
  logic digital_loop;
  logic [DWE-1:0] exp_p_dat_i = '0, exp_n_dat_i = '0;
  logic [DWE-1:0] exp_p_dat_o, exp_n_dat_o, exp_p_dir_o, exp_n_dir_o;
  logic irq_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  red_pitaya_hk_gpio_if sys_if ();

  red_pitaya_hk_gpio #(
    .DWL(DWL), .DWE(DWE), .SYNC(SYNC), .DNA_DIV(DNA_DIV), .ID(c_id), .DNA(c_dna)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .led_o        (led_o),
    .digital_loop (digital_loop),
    .exp_p_dat_i  (exp_p_dat_i),
    .exp_n_dat_i  (exp_n_dat_i),
    .exp_p_dat_o  (exp_p_dat_o),
    .exp_n_dat_o  (exp_n_dat_o),
    .exp_p_dir_o  (exp_p_dir_o),
    .exp_n_dir_o  (exp_n_dir_o),
    .irq_o        (irq_o),
    .sys          (sys_if)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Bus tasks are entered just after a falling edge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    sys_if.addr  = addr;
    sys_if.wdata = data;
    sys_if.wen   = 1'b1;
    @(negedge clk);
    sys_if.wen   = 1'b0;
    check("wr_ack", {31'd0, sys_if.ack}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    sys_if.addr = addr;
    sys_if.ren  = 1'b1;
    @(negedge clk);
    sys_if.ren  = 1'b0;
    data = sys_if.rdata;
    check("rd_ack", {31'd0, sys_if.ack}, 32'd1);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic pulse_reset();
    rstn_i = 1'b0;
    repeat (3) @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_dna();
    logic [31:0] d;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      bus_read(A_CTRL, d);
      if (d[1]) done = 1'b1;
      else repeat (10) @(negedge clk);
    end
    check("dna_done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Reference: which bits report an edge when the pads go old -> new
  function automatic logic [DWE-1:0] edges(input logic [DWE-1:0] o, input logic [DWE-1:0] n,
                                           input logic [1:0] mode);
    logic [DWE-1:0] rise, fall;
    rise = n & ~o;
    fall = o & ~n;
    return (mode[0] ? rise : '0) | (mode[1] ? fall : '0);
  endfunction

  task automatic check_blink(input string tag, input logic [DWL-1:0] led,
                             input logic [DWL-1:0] mask, input int period);
    // Entered on the falling edge right after the period write: phase 0 for
    // period+1 samples, then phase 1, and so on.
    for (int k = 0; k < 4 * (period + 1); k++) begin
      check(tag, {24'd0, led_o}, {24'd0, ((k / (period + 1)) % 2) ? (led ^ mask) : led});
      @(negedge clk);
    end
  endtask

  logic [DWE-1:0] m_dir_p, m_dir_n, m_dat_p, m_dat_n, m_en_p, m_en_n;
  logic [DWE-1:0] m_stat_p, m_stat_n, m_pad_p, m_pad_n, nw_p, nw_n, clr;
  logic [DWL-1:0] m_led, m_mask;
  logic [1:0]     m_mode;
  logic           m_loop;
  logic [31:0]    rw_addr [10];
  logic [31:0]    d, a, e;
  int             per;

  initial begin
    sys_if.addr = '0; sys_if.wdata = '0; sys_if.sel = 4'hF;
    sys_if.wen = 1'b0; sys_if.ren = 1'b0;
    m_dir_p = '0; m_dir_n = '0; m_dat_p = '0; m_dat_n = '0; m_en_p = '0; m_en_n = '0;
    m_stat_p = '0; m_stat_n = '0; m_pad_p = '0; m_pad_n = '0;
    m_led = '0; m_mask = '0; m_mode = '0; m_loop = 1'b0;
    rw_addr = '{A_CTRL, A_DIR_P, A_DIR_N, A_DAT_P, A_DAT_N, A_LED, A_MASK, A_EN_P, A_EN_N, A_MODE};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_led", {24'd0, led_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_loop", {31'd0, digital_loop}, 32'd0);
    check("rst_outs", {exp_p_dat_o, exp_n_dat_o, exp_p_dir_o, exp_n_dir_o}, 32'd0);
    check("rst_ack", {31'd0, sys_if.ack}, 32'd0);
    check("rst_rdata", sys_if.rdata, 32'd0);
    rstn_i = 1'b1;
    @(negedge clk);

    read_check("id", A_ID, c_id);
    read_check("ctrl_early", A_CTRL, 32'd0);
    read_check("dna_lo_early", A_DNA_LO, 32'd0);
    check("err", {31'd0, sys_if.err}, 32'd0);

    // ---------------- DNA ----------------
    wait_dna();
    read_check("dna_lo", A_DNA_LO, c_dna[31:0]);
    read_check("dna_hi", A_DNA_HI, {7'd0, c_dna[56:32]});

    // ---------------- random register read/write ----------------
    for (int it = 0; it < 24; it++) begin
      a = rw_addr[$urandom_range(0, 9)];
      d = $urandom;
      case (a)
        A_CTRL:  begin e = {30'd0, 1'b1, d[0]}; m_loop = d[0]; end
        A_MODE:  begin e = {30'd0, d[1:0]}; m_mode = d[1:0]; end
        A_DIR_P: begin e = {24'd0, d[7:0]}; m_dir_p = d[7:0]; end
        A_DIR_N: begin e = {24'd0, d[7:0]}; m_dir_n = d[7:0]; end
        A_DAT_P: begin e = {24'd0, d[7:0]}; m_dat_p = d[7:0]; end
        A_DAT_N: begin e = {24'd0, d[7:0]}; m_dat_n = d[7:0]; end
        A_LED:   begin e = {24'd0, d[7:0]}; m_led = d[7:0]; end
        A_MASK:  begin e = {24'd0, d[7:0]}; m_mask = d[7:0]; end
        A_EN_P:  begin e = {24'd0, d[7:0]}; m_en_p = d[7:0]; end
        default: begin e = {24'd0, d[7:0]}; m_en_n = d[7:0]; end
      endcase
      // Upper address bits must not affect decode
      bus_write(a | ($urandom << 20), d);
      read_check($sformatf("rw_%02h", a[7:0]), a, e);
    end
    check("out_dir_p", {24'd0, exp_p_dir_o}, {24'd0, m_dir_p});
    check("out_dir_n", {24'd0, exp_n_dir_o}, {24'd0, m_dir_n});
    check("out_dat_p", {24'd0, exp_p_dat_o}, {24'd0, m_dat_p});
    check("out_dat_n", {24'd0, exp_n_dat_o}, {24'd0, m_dat_n});
    check("out_led", {24'd0, led_o}, {24'd0, m_led});
    check("out_loop", {31'd0, digital_loop}, {31'd0, m_loop});

    // RO and unmapped accesses
    bus_write(A_ID, $urandom);
    read_check("id_ro", A_ID, c_id);
    bus_write(A_DNA_LO, $urandom);
    read_check("dna_ro", A_DNA_LO, c_dna[31:0]);
    bus_write(32'h3C, $urandom);
    read_check("unmapped", 32'h3C, 32'd0);
    read_check("unmapped_hi", 32'h7FC, 32'd0);

    // ---------------- output set registers ----------------
    bus_write(A_DAT_P, 32'h05);
    bus_write(A_SET_P, 32'hA0);
    read_check("set_p", A_DAT_P, 32'hA5);
    check("set_p_pad", {24'd0, exp_p_dat_o}, 32'hA5);
    read_check("set_rd0", A_SET_P, 32'd0);
    m_dat_n = DWE'($urandom);
    bus_write(A_DAT_N, {24'd0, m_dat_n});
    d = $urandom;
    bus_write(A_SET_N, d);
    m_dat_n = m_dat_n | d[7:0];
    check("set_n_pad", {24'd0, exp_n_dat_o}, {24'd0, m_dat_n});

    // ---------------- randomised edge interrupts ----------------
    for (int it = 0; it < 16; it++) begin
      m_mode = 2'($urandom_range(0, 3));
      bus_write(A_MODE, {30'd0, m_mode});
      m_en_p = DWE'($urandom);
      m_en_n = DWE'($urandom);
      bus_write(A_EN_P, {24'd0, m_en_p});
      bus_write(A_EN_N, {24'd0, m_en_n});
      nw_p = DWE'($urandom);
      nw_n = DWE'($urandom);
      m_stat_p = m_stat_p | edges(m_pad_p, nw_p, m_mode);
      m_stat_n = m_stat_n | edges(m_pad_n, nw_n, m_mode);
      m_pad_p = nw_p;
      m_pad_n = nw_n;
      exp_p_dat_i = nw_p;
      exp_n_dat_i = nw_n;
      repeat (SYNC + 3) @(negedge clk);
      read_check("in_p", A_IN_P, {24'd0, m_pad_p});
      read_check("in_n", A_IN_N, {24'd0, m_pad_n});
      read_check("stat_p", A_ST_P, {24'd0, m_stat_p});
      read_check("stat_n", A_ST_N, {24'd0, m_stat_n});
      check("irq_rand", {31'd0, irq_o},
            {31'd0, (|(m_stat_p & m_en_p)) | (|(m_stat_n & m_en_n))});
      clr = DWE'($urandom);
      bus_write(A_ST_P, {24'd0, clr});
      m_stat_p = m_stat_p & ~clr;
      clr = DWE'($urandom);
      bus_write(A_ST_N, {24'd0, clr});
      m_stat_n = m_stat_n & ~clr;
    end

    // ---------------- directed interrupt latency ----------------
    bus_write(A_MODE, 32'd0);
    exp_p_dat_i = '0;
    exp_n_dat_i = '0;
    repeat (SYNC + 3) @(negedge clk);
    bus_write(A_ST_P, 32'hFF);
    bus_write(A_ST_N, 32'hFF);
    bus_write(A_EN_N, 32'd0);
    bus_write(A_MODE, 32'd1);
    bus_write(A_EN_P, 32'h01);
    repeat (3) @(negedge clk);
    check("irq_idle", {31'd0, irq_o}, 32'd0);
    exp_p_dat_i[0] = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    check("irq_not_yet", {31'd0, irq_o}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'd0, irq_o}, 32'd1);
    read_check("stat_p_dir", A_ST_P, 32'h01);
    bus_write(A_ST_P, 32'h01);
    check("irq_hold", {31'd0, irq_o}, 32'd1);
    @(negedge clk);
    check("irq_clr", {31'd0, irq_o}, 32'd0);
    read_check("stat_p_clr", A_ST_P, 32'd0);

    // ---------------- W1C coinciding with a falling edge ----------------
    bus_write(A_EN_P, 32'd0);
    bus_write(A_MODE, 32'd2);
    bus_write(A_EN_N, 32'h08);
    exp_n_dat_i[3] = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    read_check("stat_n_rise_ignored", A_ST_N, 32'd0);
    exp_n_dat_i[3] = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    read_check("stat_n_fall", A_ST_N, 32'h08);
    check("irq_n", {31'd0, irq_o}, 32'd1);
    exp_n_dat_i[3] = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    exp_n_dat_i[3] = 1'b0;
    repeat (SYNC) @(negedge clk);
    bus_write(A_ST_N, 32'h08);   // lands on the edge that sets the bit
    repeat (2) @(negedge clk);
    check("irq_collide", {31'd0, irq_o}, 32'd1);
    read_check("stat_n_collide", A_ST_N, 32'h08);
    bus_write(A_ST_N, 32'h08);
    read_check("stat_n_clr", A_ST_N, 32'd0);

    // ---------------- LED blink ----------------
    bus_write(A_LED, 32'h0F);
    bus_write(A_MASK, 32'h03);
    bus_write(A_PER, 32'd3);
    check_blink("blink3", 8'h0F, 8'h03, 3);
    m_led = DWL'($urandom);
    m_mask = DWL'($urandom);
    per = $urandom_range(1, 6);
    bus_write(A_LED, {24'd0, m_led});
    bus_write(A_MASK, {24'd0, m_mask});
    bus_write(A_PER, per);
    check_blink("blink_rand", m_led, m_mask, per);
    bus_write(A_LED, 32'h0F);
    bus_write(A_MASK, 32'h03);
    bus_write(A_PER, 32'd0);
    for (int k = 0; k < 6; k++) begin
      check("blink_off", {24'd0, led_o}, 32'h0F);
      @(negedge clk);
    end

    // ---------------- reset in the middle of the DNA shift ----------------
    pulse_reset();
    repeat (300) @(negedge clk);
    read_check("ctrl_mid_shift", A_CTRL, 32'd0);
    pulse_reset();
    check("rst2_led", {24'd0, led_o}, 32'd0);
    check("rst2_outs", {exp_p_dat_o, exp_n_dat_o, exp_p_dir_o, exp_n_dir_o}, 32'd0);
    read_check("dna_lo_rst", A_DNA_LO, 32'd0);
    read_check("dna_hi_rst", A_DNA_HI, 32'd0);
    read_check("ctrl_rst", A_CTRL, 32'd0);
    wait_dna();
    read_check("dna_lo_again", A_DNA_LO, c_dna[31:0]);
    read_check("dna_hi_again", A_DNA_HI, {7'd0, c_dna[56:32]});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
